voice_mixer: RTL and testbench

- Downstream consumer of NUM_VOICES string-synthesis voices.
- Once per audio sample tick, collects one 18-bit signed sample from each enabled voice over the ready/received four-phase handshake.
- Sums the samples, scales the sum and pushes one mixed sample to the output sample FIFO feeding the codec interface.
- Sits between the per-voice wave generators and the codec FIFO.

---
 rtl/voice_mixer_if.sv | 26 ++
 rtl/voice_mixer.sv | 169 ++++++++++++++++
 tb/tb_voice_mixer.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/voice_mixer_if.sv
// Voice-side and output-FIFO-side signals of voice_mixer, grouped as one bus.
// master = the mixer, slave = the voices and the output FIFO.
interface voice_mixer_if #(
  parameter int NUM_VOICES = 4
);
  // Four-phase handshake per voice: the voice raises voice_ready with voice_data
  // stable, the mixer answers with voice_received, the voice drops voice_ready,
  // then the mixer drops voice_received. The mixer writes the FIFO with a
  // one-cycle out_valid strobe, and only when out_full is low.
  logic [NUM_VOICES-1:0]    voice_ready;
  logic [18*NUM_VOICES-1:0] voice_data;
  logic [NUM_VOICES-1:0]    voice_received;
  logic                     out_full;
  logic                     out_valid;
  logic [17:0]              out_sample;

  modport master (
    input  voice_ready, voice_data, out_full,
    output voice_received, out_valid, out_sample
  );

  modport slave (
    output voice_ready, voice_data, out_full,
    input  voice_received, out_valid, out_sample
  );
endinterface

// File: rtl/voice_mixer.sv
// Collects one sample per enabled voice on each sample_tick, sums, shifts and pushes to the codec FIFO.
// Define VOICE_MIXER_SATURATE_EN to clamp the scaled sum to 18 bits instead of wrapping.
module voice_mixer #(
  parameter int NUM_VOICES = 4,
  parameter int SHIFT      = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_tick,
  input  logic [NUM_VOICES-1:0] voice_en,
  voice_mixer_if.master         bus,
  output logic [7:0]            overflow_cnt,
  output logic [7:0]            miss_cnt,
  output logic                  busy,
  output logic [2:0]            dbg_state
);
  localparam int AW = 18 + $clog2(NUM_VOICES) + 1;
  localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic signed [AW-1:0] SAT_HI = AW'(131071);
  localparam logic signed [AW-1:0] SAT_LO = AW'(-131072);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ACK, S_SUM, S_PUSH} state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [WW-1:0]         wait_q, wait_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic [NUM_VOICES-1:0] rcv_q, rcv_d;
  logic                  out_valid_q, out_valid_d;
  logic [17:0]           out_sample_q, out_sample_d;
  logic [17:0]           red_q, red_d;
  logic [7:0]            ovf_q, ovf_d;
  logic [7:0]            miss_q, miss_d;

  logic [17:0]           cur_data;
  logic                  cur_en, cur_ready, last_voice, wait_done;
  logic                  advance, hs_miss, tick_miss;
  logic signed [AW-1:0]  cur_ext, scaled;
  logic [17:0]           reduced;
  logic [8:0]            miss_sum;

  always_comb begin
    cur_data   = bus.voice_data[int'(idx_q)*18 +: 18];
    cur_en     = voice_en[idx_q];
    cur_ready  = bus.voice_ready[idx_q];
    cur_ext    = {{(AW-18){cur_data[17]}}, cur_data};
    last_voice = (idx_q == IW'(NUM_VOICES - 1));
    wait_done  = (wait_q == WW'(TIMEOUT));
    scaled     = acc_q >>> SHIFT;
`ifdef VOICE_MIXER_SATURATE_EN
    if (scaled > SAT_HI)      reduced = SAT_HI[17:0];
    else if (scaled < SAT_LO) reduced = SAT_LO[17:0];
    else                      reduced = scaled[17:0];
`else
    reduced = scaled[17:0];
`endif

    state_d      = state_q;
    idx_d        = idx_q;
    wait_d       = wait_q;
    acc_d        = acc_q;
    rcv_d        = rcv_q;
    out_valid_d  = 1'b0;
    out_sample_d = out_sample_q;
    red_d        = red_q;
    ovf_d        = ovf_q;
    advance      = 1'b0;
    hs_miss      = 1'b0;

    case (state_q)
      S_IDLE: if (sample_tick) begin
        acc_d   = '0;
        idx_d   = '0;
        wait_d  = '0;
        state_d = S_REQ;
      end
      S_REQ: begin
        if (!cur_en) begin
          advance = 1'b1;
        end else if (cur_ready) begin
          acc_d        = acc_q + cur_ext;
          rcv_d[idx_q] = 1'b1;
          wait_d       = '0;
          state_d      = S_ACK;
        end else if (wait_done) begin
          hs_miss = 1'b1;
          advance = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_ACK: begin
        // A timeout here still keeps the sample captured in REQ.
        if (!cur_ready || wait_done) begin
          rcv_d   = '0;
          hs_miss = cur_ready;
          advance = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_SUM: begin
        red_d   = reduced;
        state_d = S_PUSH;
      end
      S_PUSH: begin
        if (!bus.out_full) begin
          out_valid_d  = 1'b1;
          out_sample_d = red_q;
        end else if (ovf_q != 8'hFF) begin
          ovf_d = ovf_q + 8'd1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      wait_d = '0;
      if (last_voice) begin
        state_d = S_SUM;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = S_REQ;
      end
    end

    // A busy tick and a handshake timeout can land in the same cycle; both count.
    tick_miss = sample_tick && (state_q != S_IDLE);
    miss_sum  = {1'b0, miss_q} + {8'd0, tick_miss} + {8'd0, hs_miss};
    miss_d    = miss_sum[8] ? 8'hFF : miss_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      wait_q       <= '0;
      acc_q        <= '0;
      rcv_q        <= '0;
      out_valid_q  <= 1'b0;
      out_sample_q <= '0;
      red_q        <= '0;
      ovf_q        <= '0;
      miss_q       <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      wait_q       <= wait_d;
      acc_q        <= acc_d;
      rcv_q        <= rcv_d;
      out_valid_q  <= out_valid_d;
      out_sample_q <= out_sample_d;
      red_q        <= red_d;
      ovf_q        <= ovf_d;
      miss_q       <= miss_d;
    end
  end

  assign bus.voice_received = rcv_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_sample     = out_sample_q;
  assign overflow_cnt       = ovf_q;
  assign miss_cnt           = miss_q;
  assign busy               = (state_q != S_IDLE);
  assign dbg_state          = state_q;
endmodule

// File: tb/tb_voice_mixer.sv
// Randomized bench for voice_mixer: two instances (SHIFT=2 and SHIFT=0) share stimulus
// and are scored against a per-tick arithmetic model of sum, latency and counters.
module tb_voice_mixer;
  localparam int NV      = 4;
  localparam int TIMEOUT = 8;
  localparam int M_NORMAL = 0;
  localparam int M_SILENT = 1;
  localparam int M_STUCK  = 2;

  logic          clk;
  logic          reset;
  logic          sample_tick;
  logic [NV-1:0] voice_en;
  logic [7:0]    ovf0, miss0, ovf1, miss1;
  logic          busy0, busy1;
  logic [2:0]    dbg0, dbg1;

  voice_mixer_if #(.NUM_VOICES(NV)) bus0 ();
  voice_mixer_if #(.NUM_VOICES(NV)) bus1 ();

  assign bus1.voice_ready = bus0.voice_ready;
  assign bus1.voice_data  = bus0.voice_data;
  assign bus1.out_full    = bus0.out_full;

  voice_mixer #(.NUM_VOICES(NV), .SHIFT(2), .TIMEOUT(TIMEOUT)) dut0 (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .voice_en(voice_en),
    .bus(bus0), .overflow_cnt(ovf0), .miss_cnt(miss0), .busy(busy0), .dbg_state(dbg0)
  );

  voice_mixer #(.NUM_VOICES(NV), .SHIFT(0), .TIMEOUT(TIMEOUT)) dut1 (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .voice_en(voice_en),
    .bus(bus1), .overflow_cnt(ovf1), .miss_cnt(miss1), .busy(busy1), .dbg_state(dbg1)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // stimulus configuration for the next tick
  int          v_mode [NV];
  logic [17:0] v_data [NV];
  logic [NV-1:0] cfg_en;
  logic        cfg_full;
  int          cfg_inject;   // -1 none, -2 in the PUSH cycle, else edge index

  // scoreboard / model state
  logic [17:0] exp_q[$];
  logic [17:0] exp1_q[$];
  logic [17:0] last0, last1;
  int          m_miss, m_ovf;

  function automatic logic [17:0] ref_reduce(input longint sum, input int sh);
    longint scaled;
    scaled = sum >>> sh;
`ifdef VOICE_MIXER_SATURATE_EN
    if (scaled > 131071)  scaled = 131071;
    if (scaled < -131072) scaled = -131072;
`endif
    return scaled[17:0];
  endfunction

  function automatic int sat8(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // one clock, then the voices react to what they see
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NV; i++)
      if (v_mode[i] == M_NORMAL && bus0.voice_received[i]) bus0.voice_ready[i] = 1'b0;
  endtask

  task automatic drive_voices();
    voice_en      = cfg_en;
    bus0.out_full = cfg_full;
    for (int i = 0; i < NV; i++) begin
      bus0.voice_data[i*18 +: 18] = v_data[i];
      bus0.voice_ready[i]         = (v_mode[i] != M_SILENT);
    end
  endtask

  task automatic run_tick();
    longint sum;
    int lat, inj, k, nvalid, lat_seen;
    bit bad_rcv;
    logic [17:0] got0, got1;
    sum = 0; lat = 3; nvalid = 0; lat_seen = -1; bad_rcv = 0;
    for (int i = 0; i < NV; i++) begin
      if (!cfg_en[i]) lat += 1;
      else if (v_mode[i] == M_NORMAL) begin
        lat += 2; sum += longint'($signed(v_data[i]));
      end else if (v_mode[i] == M_SILENT) begin
        lat += TIMEOUT + 1; m_miss++;
      end else begin
        lat += TIMEOUT + 2; m_miss++; sum += longint'($signed(v_data[i]));
      end
    end
    inj = (cfg_inject == -2) ? lat - 1 : cfg_inject;
    if (inj >= 0) m_miss++;
    if (cfg_full) m_ovf++;
    else begin
      exp_q.push_back(ref_reduce(sum, 2));
      exp1_q.push_back(ref_reduce(sum, 0));
    end

    drive_voices();
    sample_tick = 1'b1;
    k = 0;
    while (1) begin
      step();
      k++;
      sample_tick = (inj == k);
      if ((bus0.voice_received & ~voice_en) != 0 || !$onehot0(bus0.voice_received)) bad_rcv = 1;
      if (bus0.out_valid) begin
        nvalid++;
        lat_seen = k;
        check("dut1_valid", 32'(bus1.out_valid), 32'd1);
        if (exp_q.size() == 0) check("unexpected_push", 32'd1, 32'd0);
        else begin
          got0 = exp_q.pop_front();
          got1 = exp1_q.pop_front();
          check("sample_shift2", 32'(bus0.out_sample), 32'(got0));
          check("sample_shift0", 32'(bus1.out_sample), 32'(got1));
          last0 = got0;
          last1 = got1;
        end
      end
      if (!busy0) break;
      if (k >= 600) begin
        check("done_timeout", 32'd1, 32'd0);
        break;
      end
    end
    check("done_latency", 32'(k), 32'(lat));
    sample_tick = 1'b0;
    for (int t = 0; t < 2; t++) begin
      step();
      if (bus0.out_valid) nvalid++;
      check("busy_after", 32'(busy0), 32'd0);
    end
    check("n_valid", 32'(nvalid), cfg_full ? 32'd0 : 32'd1);
    if (!cfg_full) check("strobe_latency", 32'(lat_seen), 32'(lat));
    else check("sample_hold", 32'(bus0.out_sample), 32'(last0));
    check("received_rules", 32'(bad_rcv), 32'd0);
    check("miss_cnt", 32'(miss0), 32'(sat8(m_miss)));
    check("overflow_cnt", 32'(ovf0), 32'(sat8(m_ovf)));
    check("dut1_miss", 32'(miss1), 32'(sat8(m_miss)));
    while (exp_q.size() > 0) begin
      check("missing_push", 32'(exp_q.size()), 32'd0);
      void'(exp_q.pop_front());
      void'(exp1_q.pop_front());
    end
    exp1_q.delete();
  endtask

  task automatic set_all(input int mode, input logic [17:0] d);
    for (int i = 0; i < NV; i++) begin
      v_mode[i] = mode;
      v_data[i] = d;
    end
  endtask

  task automatic randomize_cfg();
    int r;
    cfg_en = NV'($urandom_range(0, 15));
    for (int i = 0; i < NV; i++) begin
      r = $urandom_range(0, 9);
      v_mode[i] = (r < 6) ? M_NORMAL : (r < 8) ? M_SILENT : M_STUCK;
      r = $urandom_range(0, 3);
      v_data[i] = (r == 0) ? 18'h1FFFF : (r == 1) ? 18'h20000 : 18'($urandom);
    end
    cfg_full = ($urandom_range(0, 3) == 0);
    r = $urandom_range(0, 9);
    cfg_inject = (r == 0) ? 2 : (r == 1) ? -2 : -1;
  endtask

  initial begin
    int k;
    reset = 1'b1; sample_tick = 1'b0; voice_en = '0;
    bus0.voice_ready = '0; bus0.voice_data = '0; bus0.out_full = 1'b0;
    set_all(M_NORMAL, 18'h0);
    cfg_inject = -1; m_miss = 0; m_ovf = 0; last0 = '0; last1 = '0;
    repeat (3) step();
    reset = 1'b0;
    step();
    check("rst_out_valid", 32'(bus0.out_valid), 32'd0);
    check("rst_out_sample", 32'(bus0.out_sample), 32'd0);
    check("rst_received", 32'(bus0.voice_received), 32'd0);
    check("rst_overflow", 32'(ovf0), 32'd0);
    check("rst_miss", 32'(miss0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_state", 32'(dbg0), 32'd0);

    // all voices 0x04000
    cfg_en = 4'b1111; cfg_full = 1'b0; set_all(M_NORMAL, 18'h04000);
    run_tick();
    check("plan_sample_4000", 32'(last0), 32'h04000);
    // two enabled voices at -4096
    cfg_en = 4'b0101; set_all(M_NORMAL, 18'h3F000);
    run_tick();
    check("plan_sample_m2048", 32'(last0), 32'h3F800);
    // extremes, the SHIFT=0 instance wraps or clamps
    cfg_en = 4'b1111; set_all(M_NORMAL, 18'h1FFFF);
    run_tick();
    set_all(M_NORMAL, 18'h20000);
    run_tick();
    // voice 2 silent, then served on the next tick
    set_all(M_NORMAL, 18'h00100); v_mode[2] = M_SILENT;
    run_tick();
    check("plan_sample_c0", 32'(last0), 32'h000C0);
    v_mode[2] = M_NORMAL;
    run_tick();
    // FIFO full for three ticks, then released
    cfg_full = 1'b1;
    repeat (3) run_tick();
    check("plan_overflow_3", 32'(ovf0), 32'd3);
    cfg_full = 1'b0;
    run_tick();
    // extra ticks mid-collection and in the PUSH cycle
    cfg_inject = 2;  run_tick();
    cfg_inject = -2; run_tick();
    cfg_inject = -1;

    for (int n = 0; n < 300; n++) begin
      randomize_cfg();
      run_tick();
    end
    cfg_inject = -1;

    // drive overflow_cnt into saturation
    cfg_en = '0; cfg_full = 1'b1;
    repeat (260) run_tick();
    check("overflow_saturated", 32'(ovf0), 32'd255);

    // reset while voice 1 holds the ACK phase
    cfg_en = 4'b1111; cfg_full = 1'b0; set_all(M_NORMAL, 18'h00200); v_mode[1] = M_STUCK;
    drive_voices();
    sample_tick = 1'b1;
    k = 0;
    while (1) begin
      step();
      sample_tick = 1'b0;
      k++;
      if (bus0.voice_received[1]) break;
      if (k >= 100) begin
        check("ack_wait_timeout", 32'd1, 32'd0);
        break;
      end
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_miss = 0; m_ovf = 0;
    check("rst_ack_received", 32'(bus0.voice_received), 32'd0);
    check("rst_ack_busy", 32'(busy0), 32'd0);
    check("rst_ack_valid", 32'(bus0.out_valid), 32'd0);
    for (int t = 0; t < 4; t++) begin
      step();
      check("rst_no_push", 32'(bus0.out_valid), 32'd0);
    end
    check("rst_ack_miss", 32'(miss0), 32'(m_miss));
    check("rst_ack_overflow", 32'(ovf0), 32'(m_ovf));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
